// File: rtl/ysyx_22050243_wbu_if.sv
// EXU->WBU retire handshake, LSU read-data return, GPR write port and commit trace.
interface ysyx_22050243_wbu_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int PC_WIDTH   = 64
);
   logic                  exu_valid;
   logic                  exu_ready;
   logic [PC_WIDTH-1:0]   exu_pc;
   logic                  exu_rd_wen;
   logic [ADDR_WIDTH-1:0] exu_rd_addr;
   logic [DATA_WIDTH-1:0] exu_result;
   logic                  exu_is_load;
   logic [1:0]            exu_ld_size;
   logic                  exu_ld_unsigned;
   logic [2:0]            exu_ld_offset;
   logic                  lsu_rdata_valid;
   logic [DATA_WIDTH-1:0] lsu_rdata;
   logic                  w_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  commit_valid;
   logic [PC_WIDTH-1:0]   commit_pc;
   logic [63:0]           commit_cnt;

   modport slave (
      input  exu_valid, exu_pc, exu_rd_wen, exu_rd_addr, exu_result, exu_is_load,
             exu_ld_size, exu_ld_unsigned, exu_ld_offset, lsu_rdata_valid, lsu_rdata,
      output exu_ready, w_en, w_addr, w_data, commit_valid, commit_pc, commit_cnt
   );

   modport master (
      output exu_valid, exu_pc, exu_rd_wen, exu_rd_addr, exu_result, exu_is_load,
             exu_ld_size, exu_ld_unsigned, exu_ld_offset, lsu_rdata_valid, lsu_rdata,
      input  exu_ready, w_en, w_addr, w_data, commit_valid, commit_pc, commit_cnt
   );
endinterface

// File: rtl/ysyx_22050243_wbu.sv
// Writeback unit: registered GPR write + commit pulse, 1 cycle after ALU accept or LSU data.
// Backpressure: exu_ready drops while a load waits for its read data.
module ysyx_22050243_wbu #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int PC_WIDTH   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx_22050243_wbu_if.slave    bus
);
   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] WAIT_LOAD = 1'b1;

   logic [0:0]            r_state;
   logic [PC_WIDTH-1:0]   r_ld_pc;
   logic                  r_ld_wen;
   logic [ADDR_WIDTH-1:0] r_ld_rd;
   logic [1:0]            r_ld_size;
   logic                  r_ld_uns;
   logic [2:0]            r_ld_off;

   logic                  r_w_en;
   logic [ADDR_WIDTH-1:0] r_w_addr;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic                  r_commit_valid;
   logic [PC_WIDTH-1:0]   r_commit_pc;
   logic [63:0]           r_commit_cnt;

   logic                  w_accept;
   logic [5:0]            w_shamt;
   logic [DATA_WIDTH-1:0] w_lane;
   logic [DATA_WIDTH-1:0] w_ld_val;

   assign w_accept      = bus.exu_valid && (r_state == IDLE);
   assign bus.exu_ready = (r_state == IDLE);

   assign bus.w_en         = r_w_en;
   assign bus.w_addr       = r_w_addr;
   assign bus.w_data       = r_w_data;
   assign bus.commit_valid = r_commit_valid;
   assign bus.commit_pc    = r_commit_pc;
   assign bus.commit_cnt   = r_commit_cnt;

   // Offset bits below the access size are dropped, so misaligned offsets snap to the natural lane.
   always_comb begin
      w_shamt = 6'd0;
      case (r_ld_size)
         2'b00:   w_shamt = {r_ld_off, 3'b000};
         2'b01:   w_shamt = {r_ld_off[2:1], 4'b0000};
         2'b10:   w_shamt = {r_ld_off[2], 5'b00000};
         default: w_shamt = 6'd0;
      endcase
      w_lane   = bus.lsu_rdata >> w_shamt;
      w_ld_val = w_lane;
      case (r_ld_size)
         2'b00: w_ld_val = r_ld_uns ? {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]}
                                    : {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
         2'b01: w_ld_val = r_ld_uns ? {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]}
                                    : {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
         2'b10: w_ld_val = r_ld_uns ? {{(DATA_WIDTH-32){1'b0}}, w_lane[31:0]}
                                    : {{(DATA_WIDTH-32){w_lane[31]}}, w_lane[31:0]};
         default: w_ld_val = w_lane;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_ld_pc        <= '0;
         r_ld_wen       <= 1'b0;
         r_ld_rd        <= '0;
         r_ld_size      <= 2'b00;
         r_ld_uns       <= 1'b0;
         r_ld_off       <= 3'b000;
         r_w_en         <= 1'b0;
         r_w_addr       <= '0;
         r_w_data       <= '0;
         r_commit_valid <= 1'b0;
         r_commit_pc    <= '0;
         r_commit_cnt   <= 64'd0;
      end else begin
         r_w_en         <= 1'b0;
         r_commit_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (bus.exu_is_load) begin
                     r_ld_pc   <= bus.exu_pc;
                     r_ld_wen  <= bus.exu_rd_wen;
                     r_ld_rd   <= bus.exu_rd_addr;
                     r_ld_size <= bus.exu_ld_size;
                     r_ld_uns  <= bus.exu_ld_unsigned;
                     r_ld_off  <= bus.exu_ld_offset;
                     r_state   <= WAIT_LOAD;
                  end else begin
                     if (bus.exu_rd_wen && (bus.exu_rd_addr != '0)) begin
                        r_w_en   <= 1'b1;
                        r_w_addr <= bus.exu_rd_addr;
                        r_w_data <= bus.exu_result;
                     end
                     r_commit_valid <= 1'b1;
                     r_commit_pc    <= bus.exu_pc;
                     r_commit_cnt   <= r_commit_cnt + 64'd1;
                  end
               end
            end
            default: begin
               if (bus.lsu_rdata_valid) begin
                  if (r_ld_wen && (r_ld_rd != '0)) begin
                     r_w_en   <= 1'b1;
                     r_w_addr <= r_ld_rd;
                     r_w_data <= w_ld_val;
                  end
                  r_commit_valid <= 1'b1;
                  r_commit_pc    <= r_ld_pc;
                  r_commit_cnt   <= r_commit_cnt + 64'd1;
                  r_state        <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22050243_wbu.sv
// Self-checking bench for the writeback unit: directed scenarios plus a randomized ALU/load mix.
module tb_ysyx_22050243_wbu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22050243_wbu_if bus ();

   ysyx_22050243_wbu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: architectural state visible on the write/commit ports.
   logic [4:0]  m_waddr;
   logic [63:0] m_wdata;
   logic [63:0] m_cnt;

   logic [198:0] got_t, exp_t;
   logic [134:0] got_q, exp_q;

   function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [1:0] sz,
                                            input logic uns, input logic [2:0] off);
      int nb;
      int lane;
      logic [63:0] v;
      logic [63:0] mask;
      nb   = 1 << sz;
      lane = int'(off) / nb;
      v    = d >> (lane * nb * 8);
      if (nb == 8) return v;
      mask = (64'd1 << (nb * 8)) - 64'd1;
      v    = v & mask;
      if (!uns && v[nb*8-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [198:0] m_retire(input logic wen, input logic [4:0] rd,
                                             input logic [63:0] pc, input logic [63:0] data);
      logic we;
      we = wen && (rd != 5'd0);
      if (we) begin
         m_waddr = rd;
         m_wdata = data;
      end
      m_cnt = m_cnt + 64'd1;
      return {we, m_waddr, m_wdata, 1'b1, pc, m_cnt};
   endfunction

   function automatic logic [198:0] obs();
      return {bus.w_en, bus.w_addr, bus.w_data, bus.commit_valid, bus.commit_pc, bus.commit_cnt};
   endfunction

   function automatic logic [134:0] obs_q();
      return {bus.w_en, bus.w_addr, bus.w_data, bus.commit_valid, bus.commit_cnt};
   endfunction

   function automatic logic [134:0] quiet_q();
      return {1'b0, m_waddr, m_wdata, 1'b0, m_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.exu_valid       = 1'b0;
      bus.lsu_rdata_valid = 1'b0;
   endtask

   task automatic present(input logic ld, input logic wen, input logic [4:0] rd,
                          input logic [63:0] pc, input logic [63:0] res, input logic [1:0] sz,
                          input logic uns, input logic [2:0] off);
      bus.exu_valid       = 1'b1;
      bus.exu_is_load     = ld;
      bus.exu_rd_wen      = wen;
      bus.exu_rd_addr     = rd;
      bus.exu_pc          = pc;
      bus.exu_result      = res;
      bus.exu_ld_size     = sz;
      bus.exu_ld_unsigned = uns;
      bus.exu_ld_offset   = off;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      present(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 2'b00, 1'b0, 3'd0);
      bus.exu_valid = 1'b0;
      bus.lsu_rdata = 64'd0;
      m_waddr = 5'd0; m_wdata = 64'd0; m_cnt = 64'd0;
      #22;
      n_checks++;
      if ({obs(), bus.exu_ready} !== {199'd0, 1'b1}) begin
         n_errors++;
         $display("FAIL reset_state: got %h ready=%b, want all zero ready=1", obs(), bus.exu_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alu();
      present(1'b0, 1'b1, 5'd5, 64'h8000_0000, 64'h1234, 2'b00, 1'b0, 3'd0);
      tick();
      idle_inputs();
      exp_t = m_retire(1'b1, 5'd5, 64'h8000_0000, 64'h1234);
      got_t = obs();
      n_checks++;
      if (got_t !== exp_t) begin
         n_errors++;
         $display("FAIL alu_wb: got %h want %h", got_t, exp_t);
      end
      tick();
      got_q = obs_q(); exp_q = quiet_q();
      n_checks++;
      if (got_q !== exp_q) begin
         n_errors++;
         $display("FAIL alu_wb_after: got %h want %h", got_q, exp_q);
      end
   endtask

   task automatic test_x0();
      present(1'b0, 1'b1, 5'd0, 64'h8000_0004, 64'hDEAD, 2'b00, 1'b0, 3'd0);
      tick();
      idle_inputs();
      exp_t = m_retire(1'b1, 5'd0, 64'h8000_0004, 64'hDEAD);
      got_t = obs();
      n_checks++;
      if (got_t !== exp_t) begin
         n_errors++;
         $display("FAIL x0_suppress: got %h want %h", got_t, exp_t);
      end
   endtask

   task automatic test_loads();
      logic [63:0] d [6];
      logic [1:0]  s [6];
      logic        u [6];
      logic [2:0]  o [6];
      d = '{64'h1122_3344_80AA_BBCC, 64'h1122_3344_80AA_BBCC, 64'h8765_4321_0000_0000,
            64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000, 64'hFEDC_BA98_7654_3210};
      s = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
      u = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      o = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd7, 3'd5};
      for (int i = 0; i < 6; i++) begin
         present(1'b1, 1'b1, 5'd10 + 5'(i), 64'h9000_0000 + 64'(i*4), 64'hBAD, s[i], u[i], o[i]);
         tick();
         idle_inputs();
         n_checks++;
         if (bus.exu_ready !== 1'b0 || bus.w_en !== 1'b0 || bus.commit_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL load_wait_%0d: ready=%b w_en=%b commit=%b want 0 0 0", i,
                     bus.exu_ready, bus.w_en, bus.commit_valid);
         end
         bus.lsu_rdata_valid = 1'b1;
         bus.lsu_rdata = d[i];
         tick();
         bus.lsu_rdata_valid = 1'b0;
         exp_t = m_retire(1'b1, 5'd10 + 5'(i), 64'h9000_0000 + 64'(i*4), ref_load(d[i], s[i], u[i], o[i]));
         got_t = obs();
         n_checks++;
         if (got_t !== exp_t) begin
            n_errors++;
            $display("FAIL load_%0d: got %h want %h", i, got_t, exp_t);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         present(1'b0, 1'b1, 5'd20 + 5'(i), 64'hA000_0000 + 64'(i*4), 64'h100 + 64'(i), 2'b00, 1'b0, 3'd0);
         tick();
         exp_t = m_retire(1'b1, 5'd20 + 5'(i), 64'hA000_0000 + 64'(i*4), 64'h100 + 64'(i));
         got_t = obs();
         n_checks++;
         if (got_t !== exp_t) begin
            n_errors++;
            $display("FAIL back_to_back_%0d: got %h want %h", i, got_t, exp_t);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_load_stall();
      present(1'b1, 1'b1, 5'd7, 64'hB000_0000, 64'd0, 2'b10, 1'b0, 3'd0);
      tick();
      present(1'b0, 1'b1, 5'd8, 64'hB000_0004, 64'h5555, 2'b00, 1'b0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.exu_ready !== 1'b0 || obs_q() !== quiet_q()) begin
            n_errors++;
            $display("FAIL stall_cycle_%0d: ready=%b got %h want ready=0 %h", i,
                     bus.exu_ready, obs_q(), quiet_q());
         end
         tick();
      end
      bus.lsu_rdata_valid = 1'b1;
      bus.lsu_rdata = 64'h0000_0000_FFFF_FFFF;
      tick();
      bus.lsu_rdata_valid = 1'b0;
      exp_t = m_retire(1'b1, 5'd7, 64'hB000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      got_t = obs();
      n_checks++;
      if (got_t !== exp_t || bus.exu_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_load_wb: got %h ready=%b want %h ready=1", got_t, bus.exu_ready, exp_t);
      end
      tick();
      idle_inputs();
      exp_t = m_retire(1'b1, 5'd8, 64'hB000_0004, 64'h5555);
      got_t = obs();
      n_checks++;
      if (got_t !== exp_t) begin
         n_errors++;
         $display("FAIL stall_alu_wb: got %h want %h", got_t, exp_t);
      end
   endtask

   task automatic test_stray();
      bus.lsu_rdata_valid = 1'b1;
      bus.lsu_rdata = 64'hCAFE_F00D_CAFE_F00D;
      tick();
      bus.lsu_rdata_valid = 1'b0;
      got_q = obs_q(); exp_q = quiet_q();
      n_checks++;
      if (got_q !== exp_q) begin
         n_errors++;
         $display("FAIL stray_lsu: got %h want %h", got_q, exp_q);
      end
   endtask

   task automatic test_random();
      logic        ld, wen, uns;
      logic [4:0]  rd;
      logic [63:0] pc, res, rdata;
      logic [1:0]  sz;
      logic [2:0]  off;
      int          dly;
      for (int i = 0; i < 60; i++) begin
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         ld    = 1'($urandom);
         wen   = ($urandom_range(0, 3) != 0);
         rd    = 5'($urandom);
         pc    = {$urandom, $urandom};
         res   = {$urandom, $urandom};
         rdata = {$urandom, $urandom};
         sz    = 2'($urandom);
         uns   = 1'($urandom);
         off   = 3'($urandom);
         present(ld, wen, rd, pc, res, sz, uns, off);
         tick();
         idle_inputs();
         if (ld) begin
            dly = int'($urandom_range(0, 3));
            for (int k = 0; k < dly; k++) begin
               n_checks++;
               if (bus.exu_ready !== 1'b0 || obs_q() !== quiet_q()) begin
                  n_errors++;
                  $display("FAIL rand_wait_%0d: ready=%b got %h want %h", i, bus.exu_ready,
                           obs_q(), quiet_q());
               end
               tick();
            end
            bus.lsu_rdata_valid = 1'b1;
            bus.lsu_rdata = rdata;
            tick();
            bus.lsu_rdata_valid = 1'b0;
            exp_t = m_retire(wen, rd, pc, ref_load(rdata, sz, uns, off));
         end else begin
            exp_t = m_retire(wen, rd, pc, res);
         end
         got_t = obs();
         n_checks++;
         if (got_t !== exp_t) begin
            n_errors++;
            $display("FAIL rand_%0d: ld=%b sz=%0d off=%0d uns=%b got %h want %h", i, ld, sz, off,
                     uns, got_t, exp_t);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid_load();
      present(1'b1, 1'b1, 5'd9, 64'hC000_0000, 64'd0, 2'b11, 1'b0, 3'd0);
      tick();
      idle_inputs();
      #2 rst = 1'b1;
      #1;
      m_waddr = 5'd0; m_wdata = 64'd0; m_cnt = 64'd0;
      n_checks++;
      if ({obs(), bus.exu_ready} !== {199'd0, 1'b1}) begin
         n_errors++;
         $display("FAIL reset_mid_load_async: got %h ready=%b want zero ready=1", obs(), bus.exu_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.lsu_rdata_valid = 1'b1;
      bus.lsu_rdata = 64'h1111_2222_3333_4444;
      tick();
      bus.lsu_rdata_valid = 1'b0;
      tick();
      n_checks++;
      if ({obs(), bus.exu_ready} !== {199'd0, 1'b1}) begin
         n_errors++;
         $display("FAIL reset_mid_load_after: got %h ready=%b want zero ready=1", obs(), bus.exu_ready);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_x0();
      test_loads();
      test_back_to_back();
      test_load_stall();
      test_stray();
      test_random();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ysyx_22050243_wbu.md
Name: ysyx_22050243_wbu

Overview:
Writeback unit sitting directly upstream of the GPR register file. It accepts retiring instructions from the EXU over a valid/ready handshake and waits for LSU read data on loads. It aligns and sign- or zero-extends load data. It drives the GPR write port (w_en/w_addr/w_data) from registers, and emits a one-cycle commit pulse plus a running retire counter.

Parameters:
ADDR_WIDTH, 5, GPR index width
DATA_WIDTH, 64, GPR data width (fixed at 64; load extraction assumes an 8-byte bus)
PC_WIDTH, 64, program counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
exu_valid  in  1  EXU presents a retiring instruction
exu_ready  out  1  WBU can accept this cycle
exu_pc  in  PC_WIDTH  PC of the instruction
exu_rd_wen  in  1  instruction writes rd
exu_rd_addr  in  ADDR_WIDTH  destination register
exu_result  in  DATA_WIDTH  ALU/CSR/link result (non-load)
exu_is_load  in  1  result comes from LSU
exu_ld_size  in  2  00 byte, 01 half, 10 word, 11 double
exu_ld_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
exu_ld_offset  in  3  byte offset of load address within the 8-byte word
lsu_rdata_valid  in  1  LSU read data valid (single-cycle pulse)
lsu_rdata  in  DATA_WIDTH  raw 8-byte-aligned read data
w_en  out  1  GPR write enable
w_addr  out  ADDR_WIDTH  GPR write index
w_data  out  DATA_WIDTH  GPR write data
commit_valid  out  1  one-cycle pulse per retired instruction
commit_pc  out  PC_WIDTH  PC of the retired instruction
commit_cnt  out  64  retired-instruction count, wraps modulo 2^64

Behaviour:
- States: IDLE, WAIT_LOAD.
- exu_ready = (state == IDLE). It is a combinational function of state only.
- Reset (async): state=IDLE; w_en=0, w_addr=0, w_data=0; commit_valid=0, commit_pc=0, commit_cnt=0; captured load info cleared.
- w_en and commit_valid default to 0 every cycle. Each is 1 only in the cycle after a completion.
- Accept = exu_valid && exu_ready.
- IDLE, accept, !exu_is_load (completion, latency 1): the next cycle has
  - w_en = exu_rd_wen && (exu_rd_addr != 0);
  - w_addr = exu_rd_addr; w_data = exu_result;
  - commit_valid = 1; commit_pc = exu_pc; commit_cnt += 1.
  - State stays IDLE, so back-to-back accepts give consecutive writes.
- IDLE, accept, exu_is_load: capture pc, rd_wen, rd_addr, size, unsigned and offset; go to WAIT_LOAD. No write and no commit yet.
- WAIT_LOAD: exu_ready=0 and the EXU holds its next instruction. On lsu_rdata_valid the load completes and the next cycle has:
  - w_en = captured rd_wen && rd != 0; w_addr = captured rd;
  - w_data = extracted load value; commit pulse; commit_cnt += 1.
  - State returns to IDLE.
  - Earliest completion: lsu_rdata_valid in the cycle after the accept. Load-to-write latency is 1 cycle after lsu_rdata_valid.
- lsu_rdata_valid while in IDLE is ignored: no write, no commit.
- Load extraction uses only the offset bits meaningful for the access size (natural alignment; lower offset bits are masked):
  - byte: lane = offset[2:0], bits [8*lane+7 : 8*lane];
  - half: lane = offset[2:1], 16 bits;
  - word: lane = offset[2], 32 bits;
  - double: whole word, offset ignored.
- Extension: sign-extend from the field MSB to 64 bits unless unsigned. Double ignores unsigned.
- x0: w_en is never asserted for w_addr=0. The instruction still commits and commit_cnt still increments.
- w_addr and w_data hold their last values when w_en=0.
- The GPR's same-cycle bypass covers readers of the register being written in the w_en cycle. The WBU adds no forwarding.
- Reset during WAIT_LOAD discards the pending load: no write and no commit, even if lsu_rdata_valid arrives later while in IDLE.

Test Plan:
- ALU writeback: accept with rd=5, wen=1, result=0x1234 → next cycle w_en=1, w_addr=5, w_data=0x1234, commit_valid=1, commit_cnt=1; the cycle after, w_en=0.
- x0 suppression: accept with rd=0, wen=1, result=0xDEAD → w_en=0, commit_valid=1, commit_cnt increments.
- Byte load: lb with offset=3, lsu_rdata=0x112233_4480AABBCC → w_data=0xFFFFFFFFFFFFFF80; same stimulus as lbu → 0x80.
- Word/half loads:
  - lw with offset=4, lsu_rdata=0x87654321_00000000 → 0xFFFFFFFF87654321;
  - lwu with the same stimulus → 0x0000000087654321;
  - lh with offset=7 on the same data → lane 3 → 0xFFFFFFFFFFFF8765.
- Stall and throughput:
  - three consecutive ALU accepts → w_en high for 3 consecutive cycles, commit_cnt=3;
  - load followed by an ALU instruction with lsu_rdata_valid delayed 4 cycles → exu_ready=0 for those cycles; the load write precedes the ALU write, with the ALU write 1 cycle after its accept;
  - stray lsu_rdata_valid in IDLE → no write.
- Reset mid-load: accept a load, assert rst asynchronously in WAIT_LOAD, then pulse lsu_rdata_valid → all outputs 0, exu_ready=1, commit_cnt=0, no w_en.
